// File: rtl/swarm_dispatch_grid_pkg.sv
// Shared types and helpers for the swarm dispatch grid.
package swarm_pkg;

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    DEGRADED = 2'd1,
    STALLED  = 2'd2
  } grid_mode_e;

  // Width of an index into n items, never narrower than one bit.
  function automatic int lane_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/swarm_dispatch_grid_lane.sv
// One swarm lane: saturating MAC accumulator plus stress counter.
// Stress takes increment and decay in the same edge as a single net step.
module swarm_lane
  import swarm_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 16,
  parameter int STRESS_W   = 8,
  parameter int STRESS_INC = 8,
  parameter int STRESS_DEC = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clr,
  input  logic                i_inc,
  input  logic                i_dec,
  input  logic [2*DATA_W-1:0] i_prod,
  output logic [ACC_W-1:0]    o_acc,
  output logic [STRESS_W-1:0] o_stress
);

  localparam logic signed [63:0] S_MAX  = (64'sd1 <<< STRESS_W) - 64'sd1;
  localparam logic signed [63:0] INC_S  = 64'(STRESS_INC);
  localparam logic signed [63:0] DEC_S  = 64'(STRESS_DEC);
  localparam logic signed [63:0] ZERO_S = 64'sd0;

  logic [ACC_W-1:0]    r_acc;
  logic [STRESS_W-1:0] r_stress;
  logic signed [63:0]  w_net;

  function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W-1:0] base,
                                                input logic [2*DATA_W-1:0] p);
    logic [ACC_W:0] s;
    s = {1'b0, base} + (ACC_W+1)'(p);
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  function automatic logic [STRESS_W-1:0] sat_stress(input logic signed [63:0] v);
    if (v < ZERO_S)     return '0;
    else if (v > S_MAX) return {STRESS_W{1'b1}};
    else                return v[STRESS_W-1:0];
  endfunction

  assign w_net = $signed({{(64-STRESS_W){1'b0}}, r_stress})
               + (i_inc ? INC_S : ZERO_S)
               - (i_dec ? DEC_S : ZERO_S);

  // Accumulate on dispatch and track stress; clear wins over any update.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc    <= '0;
      r_stress <= '0;
    end else if (i_clr) begin
      r_acc    <= '0;
      r_stress <= '0;
    end else begin
      if (i_inc)          r_acc    <= sat_acc(r_acc, i_prod);
      if (i_inc || i_dec) r_stress <= sat_stress(w_net);
    end
  end

  assign o_acc    = r_acc;
  assign o_stress = r_stress;

endmodule

// File: rtl/swarm_dispatch_grid.sv
// Round-robin MAC dispatcher over NUM_LANES swarm lanes with fault/stress skip.
// Optional periodic stress decay is built when SWARM_DECAY_EN is defined.
module swarm_dispatch_grid
  import swarm_pkg::*;
#(
  parameter int NUM_LANES     = 4,
  parameter int DATA_W        = 8,
  parameter int ACC_W         = 16,
  parameter int STRESS_W      = 8,
  parameter int STRESS_THRESH = 200,
  parameter int STRESS_INC    = 8,
  parameter int STRESS_DEC    = 8,
  parameter int DECAY_PERIOD  = 16,
  localparam int SEL_W        = lane_idx_w(NUM_LANES),
  localparam int TOT_W        = ACC_W + $clog2(NUM_LANES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data_a,
  input  logic [DATA_W-1:0]             in_data_b,
  input  logic [NUM_LANES-1:0]          fault_inject,
  input  logic                          acc_clr,
  output logic [NUM_LANES*ACC_W-1:0]    lane_acc,
  output logic [NUM_LANES*STRESS_W-1:0] lane_stress,
  output logic                          dispatch_valid,
  output logic [SEL_W-1:0]              lane_sel,
  output logic [TOT_W-1:0]              total_out,
  output logic [1:0]                    grid_mode
);

  logic [ACC_W-1:0]       w_acc    [NUM_LANES];
  logic [STRESS_W-1:0]    w_stress [NUM_LANES];
  logic [NUM_LANES-1:0]   w_avail;
  logic [2*NUM_LANES-1:0] w_dbl;
  logic [NUM_LANES-1:0]   w_rot;
  logic [SEL_W-1:0]       w_off, w_sel, w_rr_nxt;
  logic [SEL_W:0]         w_sum_sel, w_nxt;
  logic                   w_accept, w_do_dispatch, w_decay_tick;
  logic [2*DATA_W-1:0]    w_prod_p0;
  logic [TOT_W-1:0]       w_sum;
  grid_mode_e             r_mode, w_mode_nxt;

  logic [SEL_W-1:0]       r_rr;
  logic                   r_vld_p0, r_vld_p1;
  logic [DATA_W-1:0]      r_a_p0, r_b_p0;
  logic [SEL_W-1:0]       r_sel_p0, r_sel_p1;
  logic [TOT_W-1:0]       r_total_p2;

  // Lane availability and the handshake.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++)
      w_avail[i] = !fault_inject[i] && (w_stress[i] <= STRESS_W'(STRESS_THRESH));
  end

  assign in_ready = (|w_avail) && !acc_clr;
  assign w_accept = in_valid && in_ready;

  // Rotate availability so bit 0 is the rr pointer, then take the lowest set bit.
  assign w_dbl = {w_avail, w_avail} >> r_rr;
  assign w_rot = w_dbl[NUM_LANES-1:0];

  // Round-robin pick: first available lane at or after the pointer, wrapping.
  always_comb begin
    w_off = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--)
      if (w_rot[k]) w_off = SEL_W'(k);
    w_sum_sel = {1'b0, r_rr} + {1'b0, w_off};
    if (w_sum_sel >= (SEL_W+1)'(NUM_LANES)) w_sum_sel = w_sum_sel - (SEL_W+1)'(NUM_LANES);
    w_sel = w_sum_sel[SEL_W-1:0];
    w_nxt = {1'b0, w_sel} + (SEL_W+1)'(1);
    if (w_nxt >= (SEL_W+1)'(NUM_LANES)) w_nxt = '0;
    w_rr_nxt = w_nxt[SEL_W-1:0];
  end

  // ---- stage p0: accepted operands and target lane ----
  // Stage valid and rr pointer advance on accept; clear drops the in-flight op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p0 <= 1'b0;
      r_rr     <= '0;
    end else if (acc_clr) begin
      r_vld_p0 <= 1'b0;
      r_rr     <= '0;
    end else begin
      r_vld_p0 <= w_accept;
      if (w_accept) r_rr <= w_rr_nxt;
    end
  end

  // Operand capture; qualified by r_vld_p0 so no reset needed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a_p0   <= in_data_a;
      r_b_p0   <= in_data_b;
      r_sel_p0 <= w_sel;
    end
  end

  assign w_prod_p0     = (2*DATA_W)'(r_a_p0) * (2*DATA_W)'(r_b_p0);
  assign w_do_dispatch = r_vld_p0 && !acc_clr;

  // ---- stage p1: lane update and dispatch report ----
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    swarm_lane #(
      .DATA_W    (DATA_W),
      .ACC_W     (ACC_W),
      .STRESS_W  (STRESS_W),
      .STRESS_INC(STRESS_INC),
      .STRESS_DEC(STRESS_DEC)
    ) u_lane (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_clr   (acc_clr),
      .i_inc   (w_do_dispatch && (r_sel_p0 == SEL_W'(g))),
      .i_dec   (w_decay_tick),
      .i_prod  (w_prod_p0),
      .o_acc   (w_acc[g]),
      .o_stress(w_stress[g])
    );
    assign lane_acc[g*ACC_W +: ACC_W]          = w_acc[g];
    assign lane_stress[g*STRESS_W +: STRESS_W] = w_stress[g];
  end

  // Dispatch pulse and the lane it hit; lane_sel holds between dispatches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_sel_p1 <= '0;
    end else begin
      r_vld_p1 <= w_do_dispatch;
      if (w_do_dispatch) r_sel_p1 <= r_sel_p0;
    end
  end

  // ---- stage p2: registered grid total ----
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_LANES; i++) w_sum = w_sum + TOT_W'(w_acc[i]);
  end

  // Total follows the lane accumulators one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_total_p2 <= '0;
    else if (acc_clr) r_total_p2 <= '0;
    else              r_total_p2 <= w_sum;
  end

  // Grid mode state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_mode <= NORMAL;
    else     r_mode <= w_mode_nxt;
  end

  // Next mode straight from current availability; any mode reaches any other.
  always_comb begin
    w_mode_nxt = NORMAL;
    if (&w_avail)      w_mode_nxt = NORMAL;
    else if (|w_avail) w_mode_nxt = DEGRADED;
    else               w_mode_nxt = STALLED;
  end

`ifdef SWARM_DECAY_EN
  localparam int DC_W = lane_idx_w(DECAY_PERIOD);
  logic [DC_W-1:0] r_decay_cnt;

  assign w_decay_tick = (r_decay_cnt == DC_W'(DECAY_PERIOD - 1));

  // Free-running decay timer; every wrap bleeds stress off all lanes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_decay_cnt <= '0;
    else if (w_decay_tick) r_decay_cnt <= '0;
    else                   r_decay_cnt <= r_decay_cnt + DC_W'(1);
  end
`else
  logic w_unused_decay;
  assign w_unused_decay = (DECAY_PERIOD != 0);
  assign w_decay_tick   = 1'b0;
`endif

  assign dispatch_valid = r_vld_p1;
  assign lane_sel       = r_sel_p1;
  assign total_out      = r_total_p2;
  assign grid_mode      = r_mode;

endmodule
